switch_route_compute: RTL
=========================

Name: switch_route_compute

Overview:
- Route-compute stage downstream of the switch register bank.
- Consumes that bank's route_lut and dateline outputs, plus the head flit waiting at each input buffer.
- Produces a per-buffer requested output port and output VC, and holds them for the whole packet.
- Feeds the switch allocator and signals when a packet ends, is dropped, or misses the table.

Parameters:
- NUM_BUFFERS, 5, number of input buffers routed independently.
- NUM_OUTPORTS, 5, number of switch output ports.
- TOTAL_NODES, 4, number of node IDs in the network.
- TABLE_SIZE, 8, number of route_lut entries.

Ports:
- clk  input  1  switch clock.
- rst  input  1  reset, asynchronous, active-high.
- buf_valid  input  NUM_BUFFERS  buffer i has a flit at its head.
- buf_flit  input  NUM_BUFFERS x flit_t  head-of-buffer flit per buffer.
- flit_taken  input  NUM_BUFFERS  allocator/crossbar consumed buffer i's flit this cycle.
- route_lut  input  TABLE_SIZE x route_lut_t  routing table from the register bank; fields dest_id and out_port.
- dateline  input  NUM_OUTPORTS  port crosses the dateline.
- route_valid  output  NUM_BUFFERS  route for buffer i is valid.
- route_port  output  NUM_BUFFERS x clog2(NUM_OUTPORTS)  requested output port.
- route_vc  output  NUM_BUFFERS x 1  output VC.
- tail_out  output  NUM_BUFFERS  current flit at buffer i is the packet tail.
- drop_pop  output  NUM_BUFFERS  pop buffer i without forwarding (drop).
- route_miss  output  NUM_BUFFERS  1-cycle pulse on table miss.

Behaviour:
- Flit fields are as defined in chiplet_types_pkg:
  - vc: 1 bit.
  - dest: node ID, valid on head flits.
  - length: count of body flits following the head, 0..255, valid on head flits.
- All outputs reset to 0 and all FSMs reset to IDLE. Reset is asynchronous, takes effect mid-packet, and discards any held route.
- Each buffer has an independent FSM with states IDLE, LOOKUP, ACTIVE and DROP, plus an 8-bit remaining-flit counter rem.
- IDLE:
  - When buf_valid[i]=1, the flit is treated as a head: capture dest, vc and length into registers, then go to LOOKUP.
  - No output asserts in IDLE.
- LOOKUP (exactly 1 cycle):
  - Search route_lut for entries with dest_id == captured dest. The lowest-indexed match wins.
  - Hit:
    - route_port <= out_port.
    - route_vc <= dateline[out_port] ? 1 : captured vc.
    - rem <= length.
    - Go to ACTIVE.
  - Miss:
    - Pulse route_miss[i] for this one cycle.
    - rem <= length.
    - Go to DROP.
  - route_lut and dateline are sampled in LOOKUP only. Table changes later do not affect a route already held.
- Latency: head visible in cycle N, route_valid high from cycle N+2.
- ACTIVE:
  - route_valid=1; route_port and route_vc are held constant.
  - tail_out = (rem == 0).
  - On flit_taken[i]:
    - If rem == 0, clear route_valid and go to IDLE. The next head can be captured in that same IDLE cycle at the earliest, so back-to-back packets have a 1-cycle bubble.
    - Otherwise decrement rem.
  - With flit_taken=0, state holds indefinitely.
  - A length-0 packet has tail_out=1 on the head flit itself.
- DROP:
  - drop_pop[i] = buf_valid[i], combinational from the registered state. route_valid stays 0.
  - Each cycle drop_pop and buf_valid are both high:
    - If rem == 0, go to IDLE.
    - Otherwise decrement rem.
- Stalls: buf_valid=0 in ACTIVE or DROP stalls the counter. It is not an error.
- flit_taken[i] in any state other than ACTIVE is ignored.
- Buffers are fully independent. Multiple buffers may be in LOOKUP in the same cycle, and multiple buffers may target the same port; arbitration is downstream.
- route_port is one-hot-free: a binary index, clog2(NUM_OUTPORTS) bits, and out-of-range table values pass through unchecked.

Test Plan:
- Reset/basic:
  - Stimulus: rst high, then low. route_lut[0]={dest 2, port 3}, dateline=0. Buffer 0 head dest=2, vc=0, length=0.
  - Response: route_valid[0]=1 two cycles later with port=3, vc=0, tail_out=1. After flit_taken, route_valid drops the next cycle.
- Dateline:
  - Stimulus: same as above with dateline[3]=1.
  - Response: route_vc=1. Incoming vc=1 with dateline[3]=0 gives route_vc=1.
- Multi-flit with stalls:
  - Stimulus: length=3; flit_taken asserted with gaps.
  - Response: tail_out only on the 4th taken flit; port is stable throughout; return to IDLE after it.
- Miss/drop:
  - Stimulus: dest=1 absent from the table, length=2.
  - Response: route_miss pulses once; drop_pop is high for 3 valid cycles; route_valid stays 0; FSM returns to IDLE.
- Priority and table change:
  - Stimulus: entries 1 and 4 both match dest 0 (ports 1 and 4). Rewrite entry 1 while ACTIVE.
  - Response: port=1, unchanged until the tail.
- Concurrency/reset mid-packet:
  - Stimulus: buffers 0 and 2 head to the same dest simultaneously; assert rst mid-packet.
  - Response: both routed with identical timing. rst clears all outputs immediately (asynchronously) and FSMs restart in IDLE.

Source files
------------

// File: rtl/switch_route_compute.sv
`default_nettype none
// ============================================================================
// Module   : switch_route_compute (plus chiplet_types_pkg)
// Brief    : Per-buffer route lookup; holds port/VC for a whole packet.
// Revision : 1.0
// ============================================================================
package chiplet_types_pkg;
    localparam int NODE_W = 2;
    localparam int PORT_W = 3;

    typedef struct packed {
        logic              vc;
        logic [NODE_W-1:0] dest;
        logic [7:0]        length;
    } flit_t;

    typedef struct packed {
        logic [NODE_W-1:0] dest_id;
        logic [PORT_W-1:0] out_port;
    } route_lut_t;
endpackage

module switch_route_compute
    import chiplet_types_pkg::*;
#(
    parameter int NUM_BUFFERS  = 5,
    parameter int NUM_OUTPORTS = 5,
    parameter int TOTAL_NODES  = 4,
    parameter int TABLE_SIZE   = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic       [NUM_BUFFERS-1:0]                     buf_valid,
    input  flit_t      [NUM_BUFFERS-1:0]                     buf_flit,
    input  logic       [NUM_BUFFERS-1:0]                     flit_taken,
    input  route_lut_t [TABLE_SIZE-1:0]                      route_lut,
    input  logic       [NUM_OUTPORTS-1:0]                    dateline,
    output logic       [NUM_BUFFERS-1:0]                     route_valid,
    output logic       [NUM_BUFFERS-1:0][$clog2(NUM_OUTPORTS)-1:0] route_port,
    output logic       [NUM_BUFFERS-1:0]                     route_vc,
    output logic       [NUM_BUFFERS-1:0]                     tail_out,
    output logic       [NUM_BUFFERS-1:0]                     drop_pop,
    output logic       [NUM_BUFFERS-1:0]                     route_miss
);
    localparam int PW = $clog2(NUM_OUTPORTS);
    localparam logic [NODE_W:0] NODES_LIMIT = (NODE_W+1)'(TOTAL_NODES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ACTIVE = 2'd2,
        DROP   = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_BUFFERS; i++) begin : g_buf
        state_t            state;
        logic [NODE_W-1:0] cap_dest;
        logic              cap_vc;
        logic [7:0]        cap_len;
        logic [7:0]        rem;
        logic              rv;
        logic [PW-1:0]     rp;
        logic              rvc;
        logic              rmiss;
        logic              hit;
        logic [PW-1:0]     hit_port;
        logic              hit_dl;

        // Walk downward so the lowest-indexed matching entry is the last write.
        always_comb begin
            hit      = 1'b0;
            hit_port = '0;
            for (int j = TABLE_SIZE - 1; j >= 0; j--) begin
                if (route_lut[j].dest_id == cap_dest) begin
                    hit      = 1'b1;
                    hit_port = route_lut[j].out_port[PW-1:0];
                end
            end
            if ({1'b0, cap_dest} >= NODES_LIMIT) begin
                hit = 1'b0;
            end
        end

        // Ports beyond the dateline vector are treated as not crossing it.
        assign hit_dl = (int'(hit_port) < NUM_OUTPORTS) ? dateline[hit_port] : 1'b0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= IDLE;
                cap_dest <= '0;
                cap_vc   <= 1'b0;
                cap_len  <= '0;
                rem      <= '0;
                rv       <= 1'b0;
                rp       <= '0;
                rvc      <= 1'b0;
                rmiss    <= 1'b0;
            end else begin
                rmiss <= 1'b0;
                case (state)
                    IDLE: begin
                        if (buf_valid[i]) begin
                            cap_dest <= buf_flit[i].dest;
                            cap_vc   <= buf_flit[i].vc;
                            cap_len  <= buf_flit[i].length;
                            state    <= LOOKUP;
                        end
                    end
                    LOOKUP: begin
                        rem <= cap_len;
                        if (hit) begin
                            rv    <= 1'b1;
                            rp    <= hit_port;
                            rvc   <= hit_dl | cap_vc;
                            state <= ACTIVE;
                        end else begin
                            rmiss <= 1'b1;
                            state <= DROP;
                        end
                    end
                    ACTIVE: begin
                        if (flit_taken[i]) begin
                            if (rem == 8'd0) begin
                                rv    <= 1'b0;
                                state <= IDLE;
                            end else begin
                                rem <= rem - 8'd1;
                            end
                        end
                    end
                    DROP: begin
                        if (buf_valid[i]) begin
                            if (rem == 8'd0) begin
                                state <= IDLE;
                            end else begin
                                rem <= rem - 8'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign route_valid[i] = rv;
        assign route_port[i]  = rp;
        assign route_vc[i]    = rvc;
        assign route_miss[i]  = rmiss;
        assign tail_out[i]    = (state == ACTIVE) && (rem == 8'd0);
        assign drop_pop[i]    = (state == DROP) && buf_valid[i];
    end

endmodule
`default_nettype wire
